// File: rtl/modulo_contador_rolhas.sv
// Cork magazine stock counter with four-phase refill handshake.
// Stock saturates at MAX_ROLHAS; underflow and clipping pulse flags.
module modulo_contador_rolhas #(
  parameter int MAX_ROLHAS = 99,
  parameter int REFILL_QTY = 15,
  parameter int LOW_LEVEL  = 5
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CORK_USE,
  input  logic       CLR,
  input  logic       REFILL_ACK,
  output logic [6:0] REG_R,
  output logic       REFILL_REQ,
  output logic       EMPTY,
  output logic       LOW,
  output logic       FULL,
  output logic       USE_ERR,
  output logic       OVF
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } st_t;

  localparam logic [7:0] LP_MAX = 8'(MAX_ROLHAS);
  localparam logic [7:0] LP_QTY = 8'(REFILL_QTY);
  localparam logic [7:0] LP_LOW = 8'(LOW_LEVEL);
  localparam logic [6:0] LP_MAX7 = 7'(MAX_ROLHAS);

  st_t        r_state;
  st_t        w_next;
  logic [6:0] r_reg;
  logic       r_use_q;
  logic       r_req;
  logic       r_use_err;
  logic       r_ovf;

  logic       w_use;
  logic       w_load;
  logic       w_dec;
  logic       w_zero;
  logic       w_low;
  logic [7:0] w_sum;
  logic       w_clip;
  logic [6:0] w_nxt;

  assign w_use  = CORK_USE & ~r_use_q;
  assign w_load = (r_state == S_REQ) & REFILL_ACK;
  assign w_zero = (r_reg == 7'd0);
  assign w_low  = ({1'b0, r_reg} <= LP_LOW);
  assign w_dec  = w_use & ~w_zero;

  // 8-bit sum so a refill near the ceiling cannot wrap before clipping
  assign w_sum  = {1'b0, r_reg}
                - {7'd0, w_dec}
                + (w_load ? LP_QTY : 8'd0);
  assign w_clip = (w_sum > LP_MAX);
  assign w_nxt  = w_clip ? LP_MAX7 : w_sum[6:0];

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_low) w_next = S_REQ;
      S_REQ:  if (REFILL_ACK) w_next = S_REL;
      S_REL:  if (!REFILL_ACK) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_req   <= (w_next == S_REQ);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_reg     <= 7'd0;
      r_use_q   <= 1'b0;
      r_use_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_use_q <= CORK_USE;
      if (CLR) begin
        r_reg     <= 7'd0;
        r_use_err <= 1'b0;
        r_ovf     <= 1'b0;
      end else begin
        r_reg     <= w_nxt;
        r_use_err <= w_use & w_zero;
        r_ovf     <= w_clip;
      end
    end
  end

  assign REG_R      = r_reg;
  assign REFILL_REQ = r_req;
  assign EMPTY      = w_zero;
  assign LOW        = w_low;
  assign FULL       = (r_reg == LP_MAX7);
  assign USE_ERR    = r_use_err;
  assign OVF        = r_ovf;

endmodule

// File: tb/tb_modulo_contador_rolhas.sv
// Directed bench for modulo_contador_rolhas.
// Second instance uses a high LOW_LEVEL to reach saturation.
module tb_modulo_contador_rolhas;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       use1, clr1, ack1;
  logic       ack2;
  logic [6:0] reg1, reg2;
  logic       req1, emp1, low1, full1, uerr1, ovf1;
  logic       req2, emp2, low2, full2, uerr2, ovf2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       u;
    logic       c;
    logic       a;
    logic [6:0] er;
    logic       ereq;
    logic       euerr;
    logic       eovf;
  } vec_t;

  vec_t tab[$];

  always #5 CLK = ~CLK;

  modulo_contador_rolhas dut (
    .CLK(CLK), .RST_N(RST_N), .CORK_USE(use1), .CLR(clr1),
    .REFILL_ACK(ack1), .REG_R(reg1), .REFILL_REQ(req1),
    .EMPTY(emp1), .LOW(low1), .FULL(full1),
    .USE_ERR(uerr1), .OVF(ovf1)
  );

  modulo_contador_rolhas #(.LOW_LEVEL(95)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .CORK_USE(1'b0), .CLR(1'b0),
    .REFILL_ACK(ack2), .REG_R(reg2), .REFILL_REQ(req2),
    .EMPTY(emp2), .LOW(low2), .FULL(full2),
    .USE_ERR(uerr2), .OVF(ovf2)
  );

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [6:0] er,
                         logic ereq, logic euerr, logic eovf);
    chk({tag, ".reg"},   {1'b0, reg1}, {1'b0, er});
    chk({tag, ".req"},   {7'd0, req1}, {7'd0, ereq});
    chk({tag, ".empty"}, {7'd0, emp1}, {7'd0, er == 7'd0});
    chk({tag, ".low"},   {7'd0, low1}, {7'd0, er <= 7'd5});
    chk({tag, ".full"},  {7'd0, full1}, {7'd0, er == 7'd99});
    chk({tag, ".uerr"},  {7'd0, uerr1}, {7'd0, euerr});
    chk({tag, ".ovf"},   {7'd0, ovf1}, {7'd0, eovf});
  endtask

  task automatic cyc(logic u, logic c, logic a);
    use1 = u;
    clr1 = c;
    ack1 = a;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_tab(string tag);
    for (int i = 0; i < tab.size(); i++) begin
      cyc(tab[i].u, tab[i].c, tab[i].a);
      chk_all($sformatf("%s%0d", tag, i), tab[i].er,
              tab[i].ereq, tab[i].euerr, tab[i].eovf);
    end
    tab.delete();
  endtask

  initial begin
    RST_N = 1'b0;
    use1 = 1'b0; clr1 = 1'b0; ack1 = 1'b0; ack2 = 1'b0;
    @(posedge CLK);
    #3;
    chk_all("rst", 7'd0, 1'b0, 1'b0, 1'b0);
    #1;
    RST_N = 1'b1;

    // reset release, first handshake with ACK held 3 cycles
    tab.push_back('{1'b0, 1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 1'b0});
    tab.push_back('{1'b0, 1'b0, 1'b1, 7'd15, 1'b0, 1'b0, 1'b0});
    tab.push_back('{1'b0, 1'b0, 1'b1, 7'd15, 1'b0, 1'b0, 1'b0});
    tab.push_back('{1'b0, 1'b0, 1'b1, 7'd15, 1'b0, 1'b0, 1'b0});
    tab.push_back('{1'b0, 1'b0, 1'b0, 7'd15, 1'b0, 1'b0, 1'b0});
    tab.push_back('{1'b0, 1'b0, 1'b0, 7'd15, 1'b0, 1'b0, 1'b0});
    run_tab("hs");

    // ten use pulses, each held 3 cycles then 1 low
    for (int p = 0; p < 10; p++) begin
      for (int h = 0; h < 4; h++) begin
        cyc(h < 3, 1'b0, 1'b0);
        chk_all($sformatf("use%0d_%0d", p, h), 7'(14 - p),
                (p == 9) && (h >= 1), 1'b0, 1'b0);
      end
    end

    // simultaneous use+load, clear in RELEASE, underflow
    tab.push_back('{1'b1, 1'b0, 1'b1, 7'd19, 1'b0, 1'b0, 1'b0});
    tab.push_back('{1'b0, 1'b0, 1'b1, 7'd19, 1'b0, 1'b0, 1'b0});
    tab.push_back('{1'b0, 1'b1, 1'b1, 7'd0,  1'b0, 1'b0, 1'b0});
    tab.push_back('{1'b1, 1'b0, 1'b1, 7'd0,  1'b0, 1'b1, 1'b0});
    tab.push_back('{1'b1, 1'b0, 1'b1, 7'd0,  1'b0, 1'b0, 1'b0});
    tab.push_back('{1'b0, 1'b0, 1'b0, 7'd0,  1'b0, 1'b0, 1'b0});
    tab.push_back('{1'b0, 1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 1'b0});
    run_tab("sim");

    // asynchronous reset while REQ is high
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst.req", {7'd0, req1}, 8'd0);
    chk("midrst.reg", {1'b0, reg1}, 8'd0);
    #1;
    RST_N = 1'b1;

    // use edge together with load at zero stock
    tab.push_back('{1'b0, 1'b0, 1'b0, 7'd0,  1'b1, 1'b0, 1'b0});
    tab.push_back('{1'b1, 1'b0, 1'b1, 7'd15, 1'b0, 1'b1, 1'b0});
    tab.push_back('{1'b0, 1'b0, 1'b0, 7'd15, 1'b0, 1'b0, 1'b0});
    run_tab("zl");

    // saturation on the high-threshold instance
    RST_N = 1'b0;
    #2;
    RST_N = 1'b1;
    ack2 = 1'b0;
    @(posedge CLK);
    #1;
    chk("sat.req0", {7'd0, req2}, 8'd1);
    for (int k = 1; k <= 7; k++) begin
      int exp_r;
      exp_r = (15 * k > 99) ? 99 : 15 * k;
      ack2 = 1'b1;
      @(posedge CLK);
      #1;
      chk($sformatf("sat%0d.reg", k), {1'b0, reg2}, 8'(exp_r));
      chk($sformatf("sat%0d.ovf", k), {7'd0, ovf2},
          {7'd0, 15 * k > 99});
      chk($sformatf("sat%0d.full", k), {7'd0, full2},
          {7'd0, exp_r == 99});
      chk($sformatf("sat%0d.req", k), {7'd0, req2}, 8'd0);
      ack2 = 1'b0;
      @(posedge CLK);
      #1;
      chk($sformatf("sat%0d.ovf1", k), {7'd0, ovf2}, 8'd0);
      @(posedge CLK);
      #1;
      chk($sformatf("sat%0d.rereq", k), {7'd0, req2},
          {7'd0, exp_r <= 95});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
